// File: rtl/pipe_stage_regs_pkg.sv
// pipe_stage_regs_pkg
//   Shared constants for the elastic inter-stage pipeline registers:
//   the NOP instruction shown in empty slots, the default bus widths of the
//   EX/M-to-WB bundle, and the field layout of its control word.
package pipe_stage_regs_pkg;

  // addi x0,x0,0: presented on the instruction field of any empty slot.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Default payload and instruction widths for a riscv_core stage boundary.
  localparam int unsigned DEFAULT_DATA_W = 64;
  localparam int unsigned DEFAULT_INST_W = 32;

  // EX/M-to-WB control bundle field widths.
  localparam int unsigned LDSEL_W  = 3;
  localparam int unsigned WBSEL_W  = 2;
  localparam int unsigned REGWEN_W = 1;

  // Field offsets inside the packed control word, LSB first.
  localparam int unsigned REGWEN_LSB = 0;
  localparam int unsigned WBSEL_LSB  = REGWEN_LSB + REGWEN_W;
  localparam int unsigned LDSEL_LSB  = WBSEL_LSB + WBSEL_W;

  localparam int unsigned EXWB_CTRL_W = LDSEL_LSB + LDSEL_W;

  // Packs the EX/M-to-WB control fields into the generic ctrl bus.
  function automatic logic [EXWB_CTRL_W-1:0] pack_exwb_ctrl(
    input logic [LDSEL_W-1:0]  ld_sel,
    input logic [WBSEL_W-1:0]  wb_sel,
    input logic [REGWEN_W-1:0] reg_wen
  );
    logic [EXWB_CTRL_W-1:0] c;
    c = '0;
    c[LDSEL_LSB  +: LDSEL_W]  = ld_sel;
    c[WBSEL_LSB  +: WBSEL_W]  = wb_sel;
    c[REGWEN_LSB +: REGWEN_W] = reg_wen;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_regs_slot.sv
// pipe_stage_regs_slot
//   One register slot of the elastic pipeline: {valid, data, ctrl, inst}.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     load              slot takes its source this cycle
//     bubble            source is empty (load a bubble: ctrl=0, inst=NOP)
//     flush             kill the slot (overrides load)
//     src_data/ctrl/inst  source entry fields
//     slot_valid/data/ctrl/inst  registered slot contents
module pipe_stage_regs_slot
  import pipe_stage_regs_pkg::*;
#(
  parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned       CTRL_W   = EXWB_CTRL_W,
  parameter int unsigned       INST_W   = DEFAULT_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_stage_regs_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              flush,
  input  logic [DATA_W-1:0] src_data,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [INST_W-1:0] src_inst,
  output logic              slot_valid,
  output logic [DATA_W-1:0] slot_data,
  output logic [CTRL_W-1:0] slot_ctrl,
  output logic [INST_W-1:0] slot_inst
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [INST_W-1:0] inst_q,  inst_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    inst_d  = inst_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      inst_d  = NOP_INST;
    end else if (load) begin
      valid_d = !bubble;
      if (bubble) begin
        // Data is left as-is on a bubble; only ctrl/inst must look like a NOP.
        ctrl_d = '0;
        inst_d = NOP_INST;
      end else begin
        data_d = src_data;
        ctrl_d = src_ctrl;
        inst_d = src_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    slot_valid = valid_q;
    slot_data  = data_q;
    slot_ctrl  = ctrl_q;
    slot_inst  = inst_q;
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs
//   Elastic, parametrised inter-stage pipeline register with DEPTH slots,
//   valid/ready handshake, bubble collapsing, flush with NOP injection and
//   registered occupancy. Slot 0 is the input side, slot DEPTH-1 the head.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     in_valid/in_ready               upstream handshake
//     in_data/in_ctrl/in_inst         upstream entry
//     out_valid/out_ready             downstream handshake (head slot)
//     out_data/out_ctrl/out_inst      head entry; ctrl=0, inst=NOP when empty
//     flush                           synchronous kill of all entries
//     occupancy                       number of valid slots
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned       CTRL_W   = EXWB_CTRL_W,
  parameter int unsigned       INST_W   = DEFAULT_INST_W,
  parameter int unsigned       DEPTH    = 1,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_stage_regs_pkg::NOP_INST)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [INST_W-1:0]            in_inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [INST_W-1:0]            out_inst,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned       OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]  OCC_ONE = OCC_W'(1);

  logic              slot_valid [DEPTH];
  logic [DATA_W-1:0] slot_data  [DEPTH];
  logic [CTRL_W-1:0] slot_ctrl  [DEPTH];
  logic [INST_W-1:0] slot_inst  [DEPTH];
  logic [DEPTH-1:0]  adv;

  logic              xfer_in, xfer_out;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Advance chain, evaluated from the head back to slot 0: an empty slot
  // always accepts, so bubbles collapse and in_ready follows out_ready
  // combinationally through the valid bits.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !slot_valid[DEPTH-1] || out_ready;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      adv[DEPTH-1-i] = !slot_valid[DEPTH-1-i] || adv[DEPTH-i];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;
    logic [INST_W-1:0] src_inst;

    if (k == 0) begin : g_src_in
      always_comb begin
        src_valid = in_valid;
        src_data  = in_data;
        src_ctrl  = in_ctrl;
        src_inst  = in_inst;
      end
    end else begin : g_src_prev
      always_comb begin
        src_valid = slot_valid[k-1];
        src_data  = slot_data[k-1];
        src_ctrl  = slot_ctrl[k-1];
        src_inst  = slot_inst[k-1];
      end
    end

    pipe_stage_regs_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .INST_W   (INST_W),
      .NOP_INST (NOP_INST)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (adv[k]),
      .bubble     (!src_valid),
      .flush      (flush),
      .src_data   (src_data),
      .src_ctrl   (src_ctrl),
      .src_inst   (src_inst),
      .slot_valid (slot_valid[k]),
      .slot_data  (slot_data[k]),
      .slot_ctrl  (slot_ctrl[k]),
      .slot_inst  (slot_inst[k])
    );
  end

  always_comb begin
    in_ready  = adv[0];
    out_valid = slot_valid[DEPTH-1];
    out_data  = slot_data[DEPTH-1];
    out_ctrl  = out_valid ? slot_ctrl[DEPTH-1] : '0;
    out_inst  = out_valid ? slot_inst[DEPTH-1] : NOP_INST;
    xfer_in   = in_valid && in_ready;
    xfer_out  = out_valid && out_ready;
  end

  // Occupancy is tracked incrementally rather than by counting valid bits;
  // flush clears it regardless of any transfer in the same cycle.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (xfer_in && !xfer_out) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!xfer_in && xfer_out) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  always_comb begin
    occupancy = occ_q;
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs
//   Directed plus randomized bench for pipe_stage_regs (DEPTH=3). The
//   reference keeps a queue of in-flight entries, each tagged with its slot
//   position; every cycle each entry moves one place toward the head unless
//   the place ahead of it stays occupied.
module tb_pipe_stage_regs;
  import pipe_stage_regs_pkg::*;

  localparam int D      = 3;
  localparam int DW     = 64;
  localparam int CW     = 6;
  localparam int IW     = 32;
  localparam int OCC_W  = $clog2(D + 1);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [CW-1:0]   in_ctrl;
  logic [IW-1:0]   in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic [IW-1:0]   out_inst;
  logic            flush;
  logic [OCC_W-1:0] occupancy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int            pos;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t q[$];   // q[0] is the entry closest to the head

  pipe_stage_regs #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .INST_W   (IW),
    .DEPTH    (D),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_inst  (out_inst),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // New position of every entry after one clock; DEPTH means "left the head".
  function automatic void model_moves(input bit ordy, output int np [$]);
    int ahead;
    ahead = D;
    np.delete();
    foreach (q[i]) begin
      int p;
      if (i == 0 && q[i].pos == D - 1) begin
        p = ordy ? D : D - 1;
      end else begin
        p = q[i].pos + 1;
        if (p > ahead - 1) p = ahead - 1;
      end
      ahead = p;
      np.push_back(p);
    end
  endfunction

  function automatic bit model_in_ready(input bit ordy);
    int np [$];
    model_moves(ordy, np);
    if (np.size() == 0) return 1'b1;
    return np[np.size()-1] > 0;
  endfunction

  task automatic model_clock(input bit iv, input ent_t e, input bit ordy, input bit fl);
    int   np [$];
    bit   rdy;
    ent_t nq [$];
    rdy = model_in_ready(ordy);
    model_moves(ordy, np);
    foreach (q[i]) begin
      if (np[i] < D) begin
        ent_t t;
        t = q[i];
        t.pos = np[i];
        nq.push_back(t);
      end
    end
    if (fl) begin
      nq.delete();
    end else if (iv && rdy) begin
      e.pos = 0;
      nq.push_back(e);
    end
    q = nq;
  endtask

  task automatic check_outputs();
    bit            ev;
    logic [CW-1:0] ec;
    logic [IW-1:0] ei;
    ev = 1'b0;
    ec = '0;
    ei = NOP_INST;
    if (q.size() > 0 && q[0].pos == D - 1) begin
      ev = 1'b1;
      ec = q[0].ctrl;
      ei = q[0].inst;
    end
    check("out_valid", 64'(out_valid), 64'(ev));
    check("in_ready",  64'(in_ready),  64'(model_in_ready(out_ready)));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("out_ctrl",  64'(out_ctrl),  64'(ec));
    check("out_inst",  64'(out_inst),  64'(ei));
    if (ev) check("out_data", out_data, q[0].data);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    check({tag, "_out_ctrl"},  64'(out_ctrl),  64'h0);
    check({tag, "_out_inst"},  64'(out_inst),  64'h13);
    check({tag, "_out_data"},  out_data,       64'h0);
    check({tag, "_occupancy"}, 64'(occupancy), 64'h0);
    check({tag, "_in_ready"},  64'(in_ready),  64'h1);
  endtask

  // Drive one cycle's inputs, check outputs before the edge, advance model.
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic [IW-1:0] ins, input bit ordy, input bit fl);
    ent_t e;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    in_inst   = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    e.pos  = 0;
    e.data = d;
    e.ctrl = c;
    e.inst = ins;
    model_clock(iv, e, ordy, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    logic [CW-1:0] cst;
    cst = pack_exwb_ctrl(3'b010, 2'b01, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0;
    #7;
    check_reset("rst_hold");
    #5 rst_n = 1'b1;
    #1;
    check_reset("rst_rel");
    @(posedge clk);
    #1;

    // Streaming at full rate: 3-cycle latency, occupancy held at 3.
    cycle(1'b1, 64'h100, cst, 32'h0000_0100, 1'b1, 1'b0);
    cycle(1'b1, 64'h104, cst, 32'h0000_0104, 1'b1, 1'b0);
    cycle(1'b1, 64'h108, cst, 32'h0000_0108, 1'b1, 1'b0);
    check("stream_lat_data", out_data, 64'h100);
    check("stream_occ", 64'(occupancy), 64'h3);
    cycle(1'b1, 64'h10c, cst, 32'h0000_010c, 1'b1, 1'b0);
    check("stream_b2b_data", out_data, 64'h104);
    check("stream_occ_b2b", 64'(occupancy), 64'h3);
    idle(5, 1'b1);

    // Backpressure: fill, then hold while in_ready is low.
    cycle(1'b1, 64'h200, cst, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 64'h204, cst, 32'h204, 1'b0, 1'b0);
    cycle(1'b1, 64'h208, cst, 32'h208, 1'b0, 1'b0);
    check("bp_full_in_ready", 64'(in_ready), 64'h0);
    check("bp_full_occ", 64'(occupancy), 64'h3);
    cycle(1'b1, 64'h20c, cst, 32'h20c, 1'b0, 1'b0);
    check("bp_stable_data", out_data, 64'h200);
    cycle(1'b1, 64'h20c, cst, 32'h20c, 1'b1, 1'b0);
    check("bp_inout_occ", 64'(occupancy), 64'h3);
    idle(5, 1'b1);

    // Bubble collapse: A, gap, B with the head stalled.
    cycle(1'b1, 64'h300, cst, 32'h300, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 64'h304, cst, 32'h304, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("bubble_occ", 64'(occupancy), 64'h2);
    check("bubble_in_ready", 64'(in_ready), 64'h1);
    check("bubble_head", out_data, 64'h300);
    idle(4, 1'b1);

    // Flush of a full pipe while a new entry is offered.
    cycle(1'b1, 64'h500, 6'h3f, 32'h500, 1'b0, 1'b0);
    cycle(1'b1, 64'h504, 6'h3f, 32'h504, 1'b0, 1'b0);
    cycle(1'b1, 64'h508, 6'h3f, 32'h508, 1'b0, 1'b0);
    cycle(1'b1, 64'hdead, 6'h3f, 32'hdead, 1'b0, 1'b1);
    check("flush_occ", 64'(occupancy), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_ctrl", 64'(out_ctrl), 64'h0);
    check("flush_inst", 64'(out_inst), 64'h13);
    idle(5, 1'b1);

    // Async reset between edges with two entries in flight.
    cycle(1'b1, 64'h400, cst, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 64'h404, cst, 32'h404, 1'b0, 1'b0);
    check("arst_pre_occ", 64'(occupancy), 64'h2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset("arst");
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5, 1'b1);

    // Randomized traffic including flushes and stalls.
    for (int n = 0; n < 600; n++) begin
      bit iv, ordy, fl;
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 29) == 0);
      cycle(iv, {$urandom(), $urandom()}, CW'($urandom()), $urandom(), ordy, fl);
    end
    idle(5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
